// File: rtl/mlp_fxp_pkg.sv
// Shared fixed-point definitions for the MLP datapath: Q3.16 operand format,
// accumulator sizing and the MAC stage state encoding.
package mlp_fxp_pkg;

    localparam int DATA_W = 20;
    localparam int FRAC_W = 16;
    localparam int PROD_W = 2 * DATA_W;
    // Four guard bits keep up to 16 full-scale products plus bias from wrapping.
    localparam int ACC_W  = 2 * DATA_W + 4;

    localparam logic [DATA_W-1:0] Q_MAX = 20'h7FFFF;
    localparam logic [DATA_W-1:0] Q_MIN = 20'h80000;

    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FIN   = 2'd2,
        ST_OUT   = 2'd3
    } mac_state_e;

endpackage

// File: rtl/fxp_round_sat.sv
// Rounds a Q.32 accumulator to Q3.16 (half toward +inf) and saturates to the
// 20-bit operand range, flagging when clipping happened.
module fxp_round_sat
    import mlp_fxp_pkg::*;
(
    input  logic [ACC_W-1:0]  acc_i,
    output logic [DATA_W-1:0] data_o,
    output logic              sat_o
);

    localparam logic [ACC_W-1:0] HALF = ACC_W'(1) << (FRAC_W - 1);

    logic [ACC_W-1:0]        shifted;
    logic [ACC_W-DATA_W:0]   upper;

    // The result fits only when every bit from the Q3.16 sign upward agrees.
    always_comb begin
        shifted = $signed(acc_i + HALF) >>> FRAC_W;
        upper   = shifted[ACC_W-1:DATA_W-1];
        sat_o   = !((&upper) || !(|upper));
        if (sat_o) begin
            data_o = shifted[ACC_W-1] ? Q_MIN : Q_MAX;
        end else begin
            data_o = shifted[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/neuron_mac.sv
// Streaming multiply-accumulate for one MLP neuron: sums bias + x*w over a
// vector of beats and presents the rounded, saturated Q3.16 result.
module neuron_mac
    import mlp_fxp_pkg::*;
#(
    parameter int N_INPUTS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] x_data_i,
    input  logic [DATA_W-1:0] w_data_i,
    input  logic              in_last_i,
    input  logic [DATA_W-1:0] bias_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_sat_o
);

    mac_state_e         state_q, state_d;
    logic [PROD_W-1:0]  p_q;
    logic               p_v_q;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [DATA_W-1:0]  out_data_q;
    logic               out_sat_q;

    logic               accept;
    logic               vec_end;
    logic [PROD_W-1:0]  prod;
    logic [DATA_W-1:0]  rs_data;
    logic               rs_sat;

    assign accept  = in_valid_i && in_ready_o;
    assign vec_end = accept && (in_last_i || (cnt_q == 5'(N_INPUTS - 1)));
    assign prod    = PROD_W'($signed(x_data_i)) * PROD_W'($signed(w_data_i));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ACC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            ST_ACC:   if (vec_end) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_FIN;
            ST_FIN:   state_d = ST_OUT;
            ST_OUT:   if (out_ready_i) state_d = ST_ACC;
            default:  state_d = ST_ACC;
        endcase
    end

    always_comb begin
        in_ready_o  = (state_q == ST_ACC) && !rst;
        out_valid_o = (state_q == ST_OUT);
        out_data_o  = out_data_q;
        out_sat_o   = out_sat_q;
    end

    // The pipeline is always empty on a first beat, so bias load never collides with an add.
    always_comb begin
        acc_d = acc_q;
        if (accept && (cnt_q == 5'd0)) begin
            acc_d = {{(ACC_W-DATA_W-FRAC_W){bias_i[DATA_W-1]}}, bias_i, {FRAC_W{1'b0}}};
        end else if (p_v_q) begin
            acc_d = acc_q + {{(ACC_W-PROD_W){p_q[PROD_W-1]}}, p_q};
        end

        cnt_d = cnt_q;
        if (vec_end) begin
            cnt_d = 5'd0;
        end else if (accept) begin
            cnt_d = cnt_q + 5'd1;
        end
    end

    fxp_round_sat u_round_sat (
        .acc_i  (acc_q),
        .data_o (rs_data),
        .sat_o  (rs_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q        <= '0;
            p_v_q      <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= 5'd0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            p_v_q <= accept;
            if (accept) begin
                p_q <= prod;
            end
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            if (state_q == ST_FIN) begin
                out_data_q <= rs_data;
                out_sat_q  <= rs_sat;
            end
        end
    end

endmodule

// File: tb/tb_neuron_mac.sv
// Scoreboard bench for neuron_mac: a 64-bit integer model predicts each
// vector's result, which is queued on drive and checked when the DUT presents it.
module tb_neuron_mac;

    localparam int N_INPUTS = 4;

    typedef struct packed {
        logic [19:0] data;
        logic        sat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] x_data;
    logic [19:0] w_data;
    logic        in_last;
    logic [19:0] bias;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_data;
    logic        out_sat;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];
    logic [19:0] vx[16];
    logic [19:0] vw[16];

    always #5 clk = ~clk;

    neuron_mac #(.N_INPUTS(N_INPUTS)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .x_data_i    (x_data),
        .w_data_i    (w_data),
        .in_last_i   (in_last),
        .bias_i      (bias),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_sat_o   (out_sat)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input int n, input logic [19:0] b);
        longint acc;
        longint r;
        exp_t   e;
        acc = longint'($signed(b)) * 65536;
        for (int i = 0; i < n; i++) begin
            acc += longint'($signed(vx[i])) * longint'($signed(vw[i]));
        end
        r = (acc + 32768) >>> 16;
        if (r > 524287) begin
            e.data = 20'h7FFFF;
            e.sat  = 1'b1;
        end else if (r < -524288) begin
            e.data = 20'h80000;
            e.sat  = 1'b1;
        end else begin
            e.data = r[19:0];
            e.sat  = 1'b0;
        end
        return e;
    endfunction

    // Drives n beats from vx/vw; in_last marks the final beat only when use_last.
    task automatic send_vector(input int n, input logic [19:0] b, input bit use_last);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            x_data   = vx[i];
            w_data   = vw[i];
            bias     = (i == 0) ? b : 20'hABCDE;
            in_last  = use_last && (i == n - 1);
            check($sformatf("in_ready_beat%0d", i), in_ready, 1);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        sb.push_back(model(n, b));
        check("in_ready_drop", in_ready, 0);
    endtask

    // Waits for a result, optionally stalls it, then pops and compares.
    task automatic get_result(input int hold);
        int   lat;
        exp_t e;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("latency", lat, 2);
        e = sb.pop_front();
        check("out_valid", out_valid, 1);
        check("out_data", out_data, e.data);
        check("out_sat", out_sat, e.sat);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_data", out_data, e.data);
            check("hold_sat", out_sat, e.sat);
            check("hold_valid", out_valid, 1);
        end
        check("in_ready_out", in_ready, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("valid_clear", out_valid, 0);
        check("in_ready_back", in_ready, 1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        x_data    = '0;
        w_data    = '0;
        in_last   = 1'b0;
        bias      = '0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sat", out_sat, 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        // 2.25 * 2.0 + 0.5 = 5.0
        vx[0] = 20'h24000; vw[0] = 20'h20000;
        send_vector(1, 20'h08000, 1'b1);
        get_result(0);

        // -2.0 * 1.5 = -3.0
        vx[0] = 20'hE0000; vw[0] = 20'h18000;
        send_vector(1, 20'h00000, 1'b1);
        get_result(0);

        // Exactly half an LSB rounds up; minus half rounds to zero.
        vx[0] = 20'h00001; vw[0] = 20'h08000;
        send_vector(1, 20'h00000, 1'b1);
        get_result(0);
        vx[0] = 20'hFFFFF; vw[0] = 20'h08000;
        send_vector(1, 20'h00000, 1'b1);
        get_result(0);

        // Saturation both ways.
        for (int i = 0; i < 4; i++) begin vx[i] = 20'h70000; vw[i] = 20'h70000; end
        send_vector(4, 20'h00000, 1'b1);
        get_result(0);
        for (int i = 0; i < 4; i++) vw[i] = 20'h90000;
        send_vector(4, 20'h00000, 1'b1);
        get_result(0);

        // Count-terminated vector, then backpressure for 5 cycles.
        for (int i = 0; i < 4; i++) begin vx[i] = 20'h10000; vw[i] = 20'h10000; end
        send_vector(4, 20'h00000, 1'b0);
        get_result(5);

        // in_valid outside ACC must have no effect.
        vx[0] = 20'h30000; vw[0] = 20'h10000;
        send_vector(1, 20'h10000, 1'b1);
        in_valid = 1'b1; x_data = 20'h7FFFF; w_data = 20'h7FFFF; in_last = 1'b1;
        get_result(2);
        in_valid = 1'b0; in_last = 1'b0;

        // Abort a vector mid-way with reset.
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; x_data = 20'h30000; w_data = 20'h30000;
            bias = 20'h30000; in_last = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        check("midrst_in_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        vx[0] = 20'h10000; vw[0] = 20'h10000;
        send_vector(1, 20'h00000, 1'b1);
        get_result(0);

        // Random vectors with modest magnitudes and random stalls.
        for (int v = 0; v < 12; v++) begin
            int n;
            bit use_last;
            n = $urandom_range(1, 4);
            use_last = (n < 4) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int i = 0; i < n; i++) begin
                vx[i] = 20'($signed($urandom_range(0, 20'h3FFFF)) - 32'sh20000);
                vw[i] = 20'($signed($urandom_range(0, 20'h3FFFF)) - 32'sh20000);
            end
            send_vector(n, 20'($urandom_range(0, 20'hFFFFF)), use_last);
            get_result($urandom_range(0, 2));
        end

        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/neuron_mac.md
# neuron_mac

Fixed-point multiply-accumulate stage for one MLP neuron. Consumes a stream of (activation, weight) pairs plus a bias and produces the neuron's pre-activation sum, rounded and saturated back to the 20-bit Q3.16 operand format. The result is registered and held under a valid/ready handshake. It sits directly upstream of the CORDIC divide/activation stage (`Main`), which takes 20-bit Q3.16 operands on `x_in`/`y_in`/`z_in`.

## Interface
- `N_INPUTS`, 4: maximum beats per vector; legal range 1..16.
- `DATA_W`, 20: operand width, signed two's complement.
- `FRAC_W`, 16: fractional bits (Q3.16).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `in_valid` input 1: beat present on `x_data`/`w_data`.
- `in_ready` output 1: block accepts a beat this cycle.
- `x_data` input DATA_W: activation, Q3.16.
- `w_data` input DATA_W: weight, Q3.16.
- `in_last` input 1: final beat of the vector.
- `bias` input DATA_W: bias, Q3.16; sampled on the first accepted beat of each vector.
- `out_valid` output 1: result available.
- `out_ready` input 1: downstream consumes the result.
- `out_data` output DATA_W: rounded, saturated sum, Q3.16.
- `out_sat` output 1: saturation occurred for this result.

## Operation
**States**
- ACC: `in_ready` = 1. A beat is accepted when `in_valid && in_ready`.
- DRAIN, FIN, OUT: `in_ready` = 0.

**Per accepted beat**
- `p_q <= x_data * w_data`: 40-bit signed, Q6.32.
- `p_v <= 1`; otherwise `p_v <= 0`.
- Each cycle with `p_v` = 1: `acc <= acc + sign_ext(p_q)`.
- `acc` is 44 bits, Q.32 scaling.

**First beat of a vector**
- `acc <= sign_ext(bias) <<< FRAC_W`.
- The multiply pipeline is empty at that point, so there is no add conflict.

**Vector end**
- A vector ends on an accepted beat with `in_last` = 1, or on the N_INPUTS-th accepted beat, whichever comes first.
- The beat counter is 5 bits and clears on vector end.
- Transition ACC → DRAIN.

**Finishing the vector**
- DRAIN: performs the final accumulate, then → FIN.
- FIN: `r = (acc + 2^(FRAC_W-1)) >>> FRAC_W`, i.e. round half toward +inf.
  - If `r > 0x7FFFF`, `out_data = 0x7FFFF` and `out_sat = 1`.
  - If `r < -0x80000`, `out_data = 0x80000` and `out_sat = 1`.
  - Otherwise `out_data = r[19:0]` and `out_sat = 0`.
  - Registered, then → OUT with `out_valid = 1`.
- OUT: `out_data`/`out_sat` are held stable while `out_ready` = 0.
  - On `out_valid && out_ready`: `out_valid <= 0`, → ACC.
  - In that same cycle `in_ready` is still 0; the next vector starts the following cycle.

**Reset**
- Reset asserted in any state, including mid-vector: state → ACC, `acc`, `p_q`, `p_v` and the counter clear, and the partial vector is discarded.
- `in_ready` = 0 while `rst` = 1.

## Timing
- Reset values:
  - `out_valid` = 0, `out_data` = 0x00000, `out_sat` = 0.
  - `in_ready` = 0 during reset, and 1 in the first cycle after `rst` deasserts.
- Throughput in ACC is one beat per cycle.
- Latency: if the last beat is accepted at edge T, DRAIN occupies T→T+1, FIN occupies T+1→T+2, and `out_valid` rises after edge T+2.
- Minimum vector period is N_beats + 3 cycles when `out_ready` is tied high.
- `out_data` and `out_sat` change only on the FIN→OUT edge.
- A single-beat vector (`in_last` on the first beat) is legal. Bias load and product register on the same edge, and DRAIN adds the product.
- `in_valid` high in non-ACC states is ignored, with no side effects.

## Structure
- Shared package/include `mlp_fxp_pkg` holds:
  - DATA_W, FRAC_W.
  - Q3.16 limits: MAX = 0x7FFFF, MIN = 0x80000.
  - ACC_W = 2*DATA_W + 4.
  - State encodings ACC / DRAIN / FIN / OUT.
- One sub-module, `fxp_round_sat`: combinational, takes an ACC_W input and produces the DATA_W result plus the sat flag. It is reused by downstream activation stages.

## Test plan
- Rounding and bias:
  - Single beat x = 0x24000 (2.25), w = 0x20000 (2.0), bias = 0x08000 (0.5), `in_last` = 1 → `out_data` = 0x50000 (5.0), `out_sat` = 0.
  - `out_valid` rises exactly 2 edges after acceptance.
- Signed product: x = 0xE0000 (-2.0), w = 0x18000 (1.5), bias = 0 → 0xD0000 (-3.0).
- Half-LSB rounding: x = 0x00001, w = 0x08000, bias = 0 → 0x00001. Same with x = 0xFFFFF → 0x00000.
- Saturation: 4 beats of x = w = 0x70000 (7.0), bias = 0 → 0x7FFFF, `out_sat` = 1. Negated weights → 0x80000, `out_sat` = 1.
- Termination and backpressure:
  - N_INPUTS = 4, `in_last` never asserted: 4 beats of 1.0 × 1.0 → 0x40000, and `in_ready` drops after the 4th beat.
  - Hold `out_ready` = 0 for 5 cycles: `out_data` is stable and `in_ready` = 0 throughout.
- Reset mid-vector: accept 2 beats, pulse `rst` for 1 cycle, then send a fresh single-beat vector 1.0 × 1.0 with bias 0 → 0x10000, with no residue from the aborted vector.
